// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter: requester count,
// index width, the two FSM states and the one-hot to binary encoder that
// produces the registered grant index.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  // IDLE: nobody owns the resource. BUSY: exactly one owner.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Encode a zero-or-one-hot grant vector into the index driving the shared
  // block's select. A zero vector encodes to 0, but callers only use the
  // result alongside a real grant.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx[0] = oh[1] | oh[3];
    idx[1] = oh[2] | oh[3];
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker. Scans the unmasked request bits starting at ptr
// and wrapping past 3 back to 0, and returns the first hit as a one-hot
// vector. Purely combinational; the arbiter registers the result.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  logic [NUM_REQ-1:0] cand;
  logic [IDX_W-1:0]   pos;

  // Bits set in mask are excluded from this search.
  assign cand = req & ~mask;

  // First candidate at or after ptr wins; the index arithmetic wraps modulo 4.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    pos  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = ptr + IDX_W'(i);
      if (!any && cand[pos]) begin
        pick[pos] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and
// encoded index. An owner keeps the grant for as long as it holds its
// request; on release the next requester after the owner is granted at the
// same edge, so a busy resource never sees an idle bubble.
//
// Optional build macro ARB_TIMEOUT_EN: bounds every grant to MAX_HOLD cycles.
// When the bound is hit while the owner still requests, the grant is forcibly
// handed to the next requester (or dropped if there is none) and timeout
// pulses for one cycle. Without the macro there is no hold counter and
// timeout is tied low.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld,
  output logic               timeout
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_mask;
  logic [NUM_REQ-1:0] pick;
  logic               pick_any;

  logic               owner_req;
  logic               release_now;
  logic               force_now;
  logic               handover;

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timeout_q, timeout_d;
`endif

  // The owner is whoever idx_q points at while BUSY; its request bit decides
  // whether the grant is kept.
  assign owner_req   = req[idx_q];
  assign release_now = (state_q == ST_BUSY) && !owner_req;

`ifdef ARB_TIMEOUT_EN
  assign force_now   = (state_q == ST_BUSY) && owner_req && (hold_q == HOLD_LAST);
`else
  assign force_now   = 1'b0;
`endif

  assign handover = release_now | force_now;

  // On any handover the search restarts just after the owner. A forced
  // release masks the owner out because it is still requesting; a voluntary
  // release needs no mask since its request bit is already low.
  assign pick_ptr  = handover ? (idx_q + 2'd1) : ptr_q;
  assign pick_mask = force_now ? gnt_q : '0;

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .mask (pick_mask),
    .pick (pick),
    .any  (pick_any)
  );

  // Next-state logic: grant from IDLE, hold or hand over in BUSY.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick;
          idx_d   = onehot_to_idx(pick);
          state_d = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (handover) begin
          ptr_d = pick_ptr;
`ifdef ARB_TIMEOUT_EN
          timeout_d = force_now;
`endif
          if (pick_any) begin
            gnt_d  = pick;
            idx_d  = onehot_to_idx(pick);
`ifdef ARB_TIMEOUT_EN
            hold_d = '0;
`endif
          end else begin
            // gnt_idx keeps its last value; gnt_vld alone qualifies it.
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_d = hold_q + 1'b1;
`endif
        end
      end
    endcase
  end

  // Grant, index, pointer and state registers; reset drops any grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and the one-cycle timeout pulse after a forced release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = |gnt_q;

endmodule
